// File: rtl/ft245_cmd_pkg.sv
// Shared constants, parser state encoding and response byte selection for the FT245 command parser.
package ft245_cmd_pkg;

  localparam logic [7:0] SYNC_RX = 8'hA5;
  localparam logic [7:0] SYNC_TX = 8'h5A;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;

  localparam int unsigned PKT_LEN  = 6;
  localparam int unsigned RESP_LEN = 5;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_DH,
    ST_DL,
    ST_CHK,
    ST_EXEC,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  // Response frame: 5A ADDR RDH RDL CHK
  function automatic logic [7:0] resp_byte(input logic [IDX_W-1:0] idx,
                                           input logic [7:0]       addr,
                                           input logic [15:0]      rdata);
    logic [7:0] b;
    case (idx)
      IDX_W'(1): b = addr;
      IDX_W'(2): b = rdata[15:8];
      IDX_W'(3): b = rdata[7:0];
      IDX_W'(4): b = addr ^ rdata[15:8] ^ rdata[7:0];
      default:   b = SYNC_TX;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ft245_resp_tx.sv
// Read-response serializer: loads {addr,rdata} on a one-cycle pulse and streams the
// 5-byte frame over a valid/ready handshake; done_c flags acceptance of the last byte.
module ft245_resp_tx
  import ft245_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] rdata_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  output logic        done_c
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt_c;
  logic [7:0]       addr_q;
  logic [15:0]      rdata_q;
  logic             last_c;

  assign idx_nxt_c = idx_q + IDX_W'(1);
  assign last_c    = (idx_q == IDX_W'(RESP_LEN - 1));
  assign done_c    = tx_valid_o && tx_ready_i && last_c;

  // tx_byte_o only advances on an accepted transfer, so it is stable while stalled
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      idx_q      <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      tx_byte_o  <= '0;
      tx_valid_o <= 1'b0;
    end else if (load_i) begin
      idx_q      <= '0;
      addr_q     <= addr_i;
      rdata_q    <= rdata_i;
      tx_byte_o  <= SYNC_TX;
      tx_valid_o <= 1'b1;
    end else if (tx_valid_o && tx_ready_i) begin
      if (last_c) begin
        tx_valid_o <= 1'b0;
      end else begin
        idx_q     <= idx_nxt_c;
        tx_byte_o <= resp_byte(idx_nxt_c, addr_q, rdata_q);
      end
    end
  end

endmodule

// File: rtl/ft245_cmd_parser.sv
// FT245 6-byte command framer issuing register write/read strobes and read responses.
// Optional inter-byte idle timeout is enabled by defining RX_TIMEOUT_EN.
module ft245_cmd_parser
  import ft245_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  err_count
);

  state_e     state_q;
  logic [7:0] chk_q;
  logic [7:0] dh_q;
  logic       is_rd_q;
  logic       rd_wait_q;
  logic       load_c;
  logic       resp_done_c;
  logic       tmo_fire_c;
  logic       err_inc_c;
  logic       cmd_ok_c;

  assign cmd_ok_c = (rx_byte == CMD_WR) || (rx_byte == CMD_RD);
  // reg_rdata is valid the cycle after reg_re, i.e. the second WAIT_RD cycle
  assign load_c   = (state_q == ST_WAIT_RD) && rd_wait_q;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             in_pkt_c;

  assign in_pkt_c   = state_q inside {ST_CMD, ST_ADDR, ST_DH, ST_DL, ST_CHK};
  assign tmo_fire_c = in_pkt_c && !rx_valid && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!_reset || rx_valid || !in_pkt_c || tmo_fire_c) tmo_cnt_q <= '0;
    else                                                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
  assign tmo_fire_c = 1'b0;
`endif

  // Error sources are mutually exclusive by state, so one increment per cycle at most
  always_comb begin
    err_inc_c = tmo_fire_c;
    if (rx_valid) begin
      case (state_q)
        ST_CMD:                        err_inc_c = !cmd_ok_c;
        ST_CHK:                        err_inc_c = (rx_byte != chk_q);
        ST_EXEC, ST_WAIT_RD, ST_RESP:  err_inc_c = 1'b1;
        default:                       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q   <= ST_HUNT;
      chk_q     <= '0;
      dh_q      <= '0;
      is_rd_q   <= 1'b0;
      rd_wait_q <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (err_inc_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      if (tmo_fire_c) begin
        state_q <= ST_HUNT;
      end else begin
        case (state_q)
          ST_HUNT: if (rx_valid && (rx_byte == SYNC_RX)) state_q <= ST_CMD;
          ST_CMD: if (rx_valid) begin
            is_rd_q <= (rx_byte == CMD_RD);
            chk_q   <= rx_byte;
            state_q <= cmd_ok_c ? ST_ADDR : ST_HUNT;
          end
          ST_ADDR: if (rx_valid) begin
            reg_addr <= rx_byte;
            chk_q    <= chk_q ^ rx_byte;
            state_q  <= ST_DH;
          end
          ST_DH: if (rx_valid) begin
            dh_q    <= rx_byte;
            chk_q   <= chk_q ^ rx_byte;
            state_q <= ST_DL;
          end
          ST_DL: if (rx_valid) begin
            reg_wdata <= {dh_q, rx_byte};
            chk_q     <= chk_q ^ rx_byte;
            state_q   <= ST_CHK;
          end
          ST_CHK: if (rx_valid) begin
            if (rx_byte == chk_q) begin
              state_q <= ST_EXEC;
              busy    <= 1'b1;
            end else begin
              state_q <= ST_HUNT;
            end
          end
          ST_EXEC: begin
            if (is_rd_q) begin
              reg_re    <= 1'b1;
              rd_wait_q <= 1'b0;
              state_q   <= ST_WAIT_RD;
            end else begin
              reg_we  <= 1'b1;
              busy    <= 1'b0;
              state_q <= ST_HUNT;
            end
          end
          ST_WAIT_RD: begin
            rd_wait_q <= 1'b1;
            if (rd_wait_q) state_q <= ST_RESP;
          end
          ST_RESP: if (resp_done_c) begin
            busy    <= 1'b0;
            state_q <= ST_HUNT;
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  ft245_resp_tx u_resp_tx (
    .clk        (clk),
    .rst_n_i    (_reset),
    .load_i     (load_c),
    .addr_i     (reg_addr),
    .rdata_i    (reg_rdata),
    .tx_ready_i (tx_ready),
    .tx_byte_o  (tx_byte),
    .tx_valid_o (tx_valid),
    .done_c     (resp_done_c)
  );

endmodule
